load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU decoder/ALU.
- Consumes the effective address (ALU result), store data, MemRead/MemWrite and the 2-bit DataType produced by the decoder, then runs a multi-cycle request/acknowledge transaction with the data memory.
- Generates byte enables and lane-aligned write data for stores; extracts and zero-extends load data.
- Holds the pipeline through Stall until the access completes.

Parameters:
- ADDR_WIDTH, 32, width of the address path and of mem_addr.
- TIMEOUT, 255, maximum BUSY cycles without mem_ack before a bus error is declared; range 1..1023.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- MemRead  in  1  load request (op5=0 load class).
- MemWrite  in  1  store request.
- DataType  in  2  00 word (lw/sw), 01 byte (lbu/sb), 10 half (lhu/sh), 11 illegal.
- Addr  in  ADDR_WIDTH  effective byte address.
- WriteData  in  32  store data, right-justified.
- Stall  out  1  freeze the upstream pipeline.
- ReadData  out  32  zero-extended load result, valid while Done=1.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  one-cycle pulse on misalign, illegal or timeout.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_WIDTH  word-aligned address, Addr with bits [1:0] forced to 00.
- mem_wdata  out  32  lane-replicated write data.
- mem_be  out  4  byte enables.
- mem_ack  in  1  memory accepts the write or returns read data this cycle.
- mem_rdata  in  32  read word, valid with mem_ack.

Behaviour:
- Reset: state IDLE; all outputs 0; timeout counter 0. Reset mid-transaction aborts it immediately: mem_req drops the next cycle and no Done/Err is issued.
- States: IDLE, BUSY, DONE.
- IDLE, request present (MemRead^MemWrite):
  - Legal: latch Addr, WriteData, DataType and direction. Stall=1 combinationally. Next state BUSY.
  - Illegal: MemRead&MemWrite, DataType=11, lw/sw with Addr[1:0]≠0, or half with Addr[0]≠0. No memory access; Err pulses next cycle; Stall stays 0; stay in IDLE.
- BUSY:
  - mem_req=1 with stable mem_we/mem_addr/mem_be/mem_wdata; Stall=1.
  - Counter increments each cycle.
  - mem_ack: capture and align mem_rdata for loads; go DONE; mem_req=0 from the next cycle.
  - Counter reaches TIMEOUT with no ack: ReadData=0; Err pulses together with Done; go DONE.
- DONE:
  - Done=1 and ReadData valid for exactly one cycle.
  - Stall=0 so the instruction advances at this clock edge.
  - Requests are ignored this cycle, which prevents re-issuing the same instruction; return to IDLE.
- mem_ack outside BUSY is ignored.
- Latency: request in cycle 0, mem_req in cycles 1..k, ack in cycle k, Done in cycle k+1. The minimum is 3 cycles, with ack in cycle 1.
- Store lanes, with lane = Addr[1:0]:
  - sw: be=1111, wdata=WriteData.
  - sb: be=0001<<lane, wdata={4{WriteData[7:0]}}.
  - sh: be=0011 (lane 0) or 1100 (lane 2), wdata={2{WriteData[15:0]}}.
- Load extract:
  - lw: full word.
  - lbu: mem_rdata[8*lane+:8], zero-extended.
  - lhu: mem_rdata[16*lane[1]+:16], zero-extended.
- Store completion returns ReadData=0.

Decomposition:
- Package lsu_pkg:
  - localparams DT_WORD=2'b00, DT_BYTE=2'b01, DT_HALF=2'b10, DT_ILLEGAL=2'b11.
  - Enum lsu_state_t {IDLE, BUSY, DONE}.
  - Function is_aligned(DataType, lane).
- Sub-module lsu_lane_align: purely combinational; inputs DataType, lane, WriteData, mem_rdata; outputs be, wdata, rdata_ext. It is instantiated once and unit-tested separately.
- The FSM and timeout counter stay in load_store_unit.

Test Plan:
- sb, Addr=0x1002, WriteData=0xA5, ack in cycle 1 -> mem_addr=0x1000, mem_be=0100, mem_wdata=0xA5A5A5A5, mem_we=1; Done in cycle 2; Stall high in cycles 0-1.
- lbu, Addr=0x2003, mem_rdata=0x80FF_1234, ack after 4 BUSY cycles -> ReadData=0x00000080 with Done in cycle 5; Stall high in cycles 0-4.
- lhu, Addr=0x2002, mem_rdata=0xBEEF_CAFE -> ReadData=0x0000BEEF; lw, Addr=0x2000 -> ReadData=0xBEEFCAFE.
- lw at Addr=0x2001, then sh at 0x2003, then MemRead=MemWrite=1 -> Err pulse for each; mem_req never asserted; Stall stays 0.
- TIMEOUT=8, mem_ack tied low -> mem_req high for 8 cycles, then Done=1 and Err=1 together, ReadData=0, FSM back in IDLE.
- rst asserted in the third BUSY cycle, then ack arrives -> mem_req=0 the next cycle, no Done/Err, state IDLE; a fresh sw afterwards completes normally with be=1111.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: access-size codes,
// FSM state encoding and the alignment rule.
package lsu_pkg;

  localparam logic [1:0] DT_WORD    = 2'b00;
  localparam logic [1:0] DT_BYTE    = 2'b01;
  localparam logic [1:0] DT_HALF    = 2'b10;
  localparam logic [1:0] DT_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} lsu_state_t;

  // Byte accesses are always aligned; halves need an even address, words a multiple of 4.
  function automatic logic is_aligned(input logic [1:0] dt, input logic [1:0] lane);
    case (dt)
      DT_WORD: is_aligned = (lane == 2'b00);
      DT_BYTE: is_aligned = 1'b1;
      DT_HALF: is_aligned = (lane[0] == 1'b0);
      default: is_aligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering: byte enables and replicated store data going
// out, zero-extended lane extraction coming back.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  DataType,
  input  logic [1:0]  lane,
  input  logic [31:0] WriteData,
  input  logic [31:0] mem_rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] rdata_ext
);

  always_comb begin
    be        = 4'b0000;
    wdata     = 32'h0;
    rdata_ext = 32'h0;
    case (DataType)
      DT_WORD: begin
        be        = 4'b1111;
        wdata     = WriteData;
        rdata_ext = mem_rdata;
      end
      DT_BYTE: begin
        be        = 4'b0001 << lane;
        wdata     = {4{WriteData[7:0]}};
        rdata_ext = {24'h0, mem_rdata[{lane, 3'b000} +: 8]};
      end
      DT_HALF: begin
        be        = lane[1] ? 4'b1100 : 4'b0011;
        wdata     = {2{WriteData[15:0]}};
        rdata_ext = {16'h0, mem_rdata[{lane[1], 4'b0000} +: 16]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: validates the request, runs a req/ack transaction with
// data memory under a timeout, and stalls the pipeline until it completes.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [1:0]            DataType,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [31:0]           WriteData,
  output logic                  Stall,
  output logic [31:0]           ReadData,
  output logic                  Done,
  output logic                  Err,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [31:0]           mem_rdata
);

  localparam int CNT_W = 10;

  lsu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       dt_q, lane_q;
  logic [1:0]       dt_sel, lane_sel;
  logic             req_any, legal, accept;
  logic [3:0]       be;
  logic [31:0]      wdata, rdata_ext;

  assign req_any = MemRead | MemWrite;
  assign legal   = (MemRead ^ MemWrite) && is_aligned(DataType, Addr[1:0]);
  assign accept  = (state == IDLE) && req_any && legal;
  assign Stall   = accept || (state == BUSY);

  // One aligner serves both directions: live inputs while accepting, latched size/lane while waiting for read data.
  assign dt_sel   = (state == IDLE) ? DataType  : dt_q;
  assign lane_sel = (state == IDLE) ? Addr[1:0] : lane_q;

  lsu_lane_align u_align (
    .DataType  (dt_sel),
    .lane      (lane_sel),
    .WriteData (WriteData),
    .mem_rdata (mem_rdata),
    .be        (be),
    .wdata     (wdata),
    .rdata_ext (rdata_ext)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      dt_q   <= DataType;
      lane_q <= Addr[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      ReadData  <= 32'h0;
      Done      <= 1'b0;
      Err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      mem_be    <= 4'b0000;
    end else begin
      Done     <= 1'b0;
      Err      <= 1'b0;
      ReadData <= 32'h0;
      case (state)
        IDLE: begin
          if (req_any) begin
            if (legal) begin
              state     <= BUSY;
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= MemWrite;
              mem_addr  <= {Addr[ADDR_WIDTH-1:2], 2'b00};
              mem_be    <= be;
              mem_wdata <= MemWrite ? wdata : 32'h0;
            end else begin
              Err <= 1'b1;
            end
          end
        end
        BUSY: begin
          cnt <= cnt + 1'b1;
          if (mem_ack) begin
            state    <= DONE;
            mem_req  <= 1'b0;
            Done     <= 1'b1;
            ReadData <= mem_we ? 32'h0 : rdata_ext;
          end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
            state   <= DONE;
            mem_req <= 1'b0;
            Done    <= 1'b1;
            Err     <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
